// File: rtl/coraz7_btn_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, stability-count debounce, press/release pulses.
// Optional long-press pulse generation is enabled by defining CORAZ7_BTN_LONG_PRESS_EN.
module coraz7_btn_conditioner #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int LONG_CYCLES     = 125000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_i,
  output logic [NUM_BTN-1:0] btn_level_o,
  output logic [NUM_BTN-1:0] btn_press_o,
  output logic [NUM_BTN-1:0] btn_release_o,
  output logic [NUM_BTN-1:0] btn_long_o
);

  localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_param_check
    $error("coraz7_btn_conditioner: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
  end

  logic [NUM_BTN-1:0] r_sync_ff1;
  logic [NUM_BTN-1:0] r_sync_s;
  logic [CNT_W-1:0]   r_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] r_level;
  logic [NUM_BTN-1:0] r_press;
  logic [NUM_BTN-1:0] r_release;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_ff1 <= '0;
      r_sync_s   <= '0;
    end else begin
      r_sync_ff1 <= btn_i;
      r_sync_s   <= r_sync_ff1;
    end
  end

  // NOTE: the counter array is reset too, so a reset mid-debounce cannot leave a partial count behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BTN; i++) r_cnt[i] <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        r_press[i]   <= 1'b0;
        r_release[i] <= 1'b0;
        if (r_sync_s[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] != CNT_MAX) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end else begin
          // Stable long enough: commit the new level and flag the matching edge.
          r_cnt[i]     <= '0;
          r_level[i]   <= r_sync_s[i];
          r_press[i]   <= r_sync_s[i];
          r_release[i] <= ~r_sync_s[i];
        end
      end
    end
  end

  assign btn_level_o   = r_level;
  assign btn_press_o   = r_press;
  assign btn_release_o = r_release;

`ifdef CORAZ7_BTN_LONG_PRESS_EN
  localparam int               HOLD_W   = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0]  r_hold [NUM_BTN];
  logic [NUM_BTN-1:0] r_long;

  // Saturating hold counter: one long pulse per press, rearmed when the level drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BTN; i++) r_hold[i] <= '0;
      r_long <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        r_long[i] <= 1'b0;
        if (!r_level[i]) begin
          r_hold[i] <= '0;
        end else if (r_hold[i] != HOLD_MAX) begin
          r_hold[i] <= r_hold[i] + HOLD_W'(1);
          r_long[i] <= (r_hold[i] == HOLD_MAX - HOLD_W'(1));
        end
      end
    end
  end

  assign btn_long_o = r_long;
`else
  assign btn_long_o = '0;
`endif

endmodule

// File: tb/tb_coraz7_btn_conditioner.sv
// Directed bench for coraz7_btn_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=10, NUM_BTN=2.
// Long-press expectations follow CORAZ7_BTN_LONG_PRESS_EN when it is defined for the build.
module tb_coraz7_btn_conditioner;

  localparam int NUM_BTN = 2;
  localparam int DEB     = 4;
  localparam int LONG    = 10;
  localparam int RISE_T  = DEB + 2;          // ticks from input change to new level
  localparam int LONG_T  = RISE_T + LONG;    // ticks from input change to long pulse
`ifdef CORAZ7_BTN_LONG_PRESS_EN
  localparam bit LONG_BUILD = 1'b1;
`else
  localparam bit LONG_BUILD = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic [NUM_BTN-1:0] btn_i;
  logic [NUM_BTN-1:0] btn_level_o;
  logic [NUM_BTN-1:0] btn_press_o;
  logic [NUM_BTN-1:0] btn_release_o;
  logic [NUM_BTN-1:0] btn_long_o;

  int checks = 0;
  int errors = 0;

  coraz7_btn_conditioner #(
    .NUM_BTN        (NUM_BTN),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_i        (btn_i),
    .btn_level_o  (btn_level_o),
    .btn_press_o  (btn_press_o),
    .btn_release_o(btn_release_o),
    .btn_long_o   (btn_long_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // One clock: the rising edge happens, outputs are then sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] outs();
    return {btn_level_o, btn_press_o, btn_release_o, btn_long_o};
  endfunction

  task automatic test_reset();
    logic [7:0] obs;
    rst_n = 1'b0;
    btn_i = 2'b00;
    repeat (3) @(negedge clk);
    obs = outs();
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: outputs={lvl,prs,rel,lng}=%b expected %b", obs, 8'h00);
    end
    rst_n = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      obs = outs();
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle t=%0d: outputs=%b expected %b", t, obs, 8'h00);
      end
    end
  endtask

  // Drive btn_i to 'val' and check the outputs every tick for 'n' ticks.
  // from/to give the level before and after the commit at tick RISE_T.
  task automatic drive_and_check(input string name, input logic [1:0] val,
                                 input logic [1:0] from, input int n, input int long_at);
    logic [7:0] obs, exp;
    logic [1:0] lvl, prs, rel, lng;
    btn_i = val;
    for (int t = 1; t <= n; t++) begin
      tick();
      lvl = (t >= RISE_T) ? val : from;
      prs = (t == RISE_T) ? (val & ~from) : 2'b00;
      rel = (t == RISE_T) ? (from & ~val) : 2'b00;
      lng = (LONG_BUILD && t == long_at) ? 2'b01 : 2'b00;
      exp = {lvl, prs, rel, lng};
      obs = outs();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s t=%0d: outputs={lvl,prs,rel,lng}=%b expected %b", name, t, obs, exp);
      end
    end
  endtask

  // Drive a short input burst during which no output may change from 'lvl'.
  task automatic drive_quiet(input string name, input logic [1:0] val, input logic [1:0] lvl,
                             input int n);
    logic [7:0] obs, exp;
    btn_i = val;
    exp   = {lvl, 6'b0};
    for (int t = 1; t <= n; t++) begin
      tick();
      obs = outs();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s t=%0d: outputs=%b expected %b", name, t, obs, exp);
      end
    end
  endtask

  task automatic test_single_press();
    drive_and_check("press0", 2'b01, 2'b00, 8, 0);
    drive_and_check("release0", 2'b00, 2'b01, 8, 0);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 4; i++)
      drive_quiet("bounce", (i % 2 == 0) ? 2'b01 : 2'b00, 2'b00, 1);
    drive_and_check("bounce_settle", 2'b01, 2'b00, 8, 0);
    drive_and_check("bounce_release", 2'b00, 2'b01, 8, 0);
    // Glitch low just before the count would have committed.
    drive_quiet("glitch_hi", 2'b01, 2'b00, 3);
    drive_quiet("glitch_lo", 2'b00, 2'b00, 1);
    drive_and_check("glitch_settle", 2'b01, 2'b00, 8, 0);
    drive_and_check("glitch_release", 2'b00, 2'b01, 8, 0);
  endtask

  task automatic test_back_to_back();
    drive_and_check("both_press", 2'b11, 2'b00, 8, 0);
    drive_and_check("both_release", 2'b00, 2'b11, 8, 0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] obs;
    drive_quiet("mid_count", 2'b10, 2'b00, 4);
    rst_n = 1'b0;
    #1;
    obs = outs();
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_count: outputs=%b expected %b", obs, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_and_check("after_reset", 2'b10, 2'b00, RISE_T, 0);
    // Reset while the press pulse is high: everything clears at once.
    rst_n = 1'b0;
    #1;
    obs = outs();
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_pulse: outputs=%b expected %b", obs, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_and_check("held_through_reset", 2'b10, 2'b00, 8, 0);
    drive_and_check("release1", 2'b00, 2'b10, 8, 0);
  endtask

  task automatic test_long_press();
    drive_and_check("long_hold", 2'b01, 2'b00, LONG_T + 12, LONG_T);
    drive_and_check("long_release", 2'b00, 2'b01, 8, 0);
    drive_and_check("long_repress", 2'b01, 2'b00, LONG_T + 4, LONG_T);
    drive_and_check("long_release2", 2'b00, 2'b01, 8, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    btn_i = 2'b00;
    test_reset();
    test_single_press();
    test_bounce();
    test_back_to_back();
    test_reset_mid();
    test_long_press();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
